// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Contents: FSM state encoding, stage-control bundle ordering, MD_LAT range limits.
// Also holds the helper that derives the mul/div counter reload value.
package pipe_pkg;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    // Stage-control bundle: load enables first (PC towards WB), then clears in the same order.
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_r;
        logic id_ex_r;
        logic ex_mem_r;
        logic mem_wb_r;
    } stage_ctl_t;

    localparam int MD_LAT_MIN = 2;
    localparam int MD_LAT_MAX = 255;

    // Normal advance: everything loads, nothing clears.
    localparam stage_ctl_t CTL_ADVANCE = '{
        pc_en: 1'b1, if_id_en: 1'b1, id_ex_en: 1'b1, ex_mem_en: 1'b1, mem_wb_en: 1'b1,
        if_id_r: 1'b0, id_ex_r: 1'b0, ex_mem_r: 1'b0, mem_wb_r: 1'b0
    };

    // Held while reset is asserted: nothing loads, every stage register is cleared.
    localparam stage_ctl_t CTL_RESET = '{
        pc_en: 1'b0, if_id_en: 1'b0, id_ex_en: 1'b0, ex_mem_en: 1'b0, mem_wb_en: 1'b0,
        if_id_r: 1'b1, id_ex_r: 1'b1, ex_mem_r: 1'b1, mem_wb_r: 1'b1
    };

    // Reload value for the occupancy counter; out-of-range latencies are clamped
    // so the counter can never start at 0 or overflow its 8 bits.
    function automatic logic [7:0] md_cnt_load(input int lat);
        int lat_c;
        lat_c = lat;
        if (lat_c < MD_LAT_MIN) lat_c = MD_LAT_MIN;
        if (lat_c > MD_LAT_MAX) lat_c = MD_LAT_MAX;
        return 8'(lat_c - 1);
    endfunction

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard comparator: flags an ID source that depends on a load in EX.
// Ports: ID source indices + use flags, EX destination index + load flag in; hazard flag out.
// Purely combinational, no latency; x0 as a destination never flags a hazard.
module hazard_detect
    import pipe_pkg::*;
#(
    parameter int RW = 5
) (
    input  logic [RW-1:0] i_id_rs1,
    input  logic [RW-1:0] i_id_rs2,
    input  logic          i_id_rs1_used,
    input  logic          i_id_rs2_used,
    input  logic [RW-1:0] i_ex_rd,
    input  logic          i_ex_mem_read,
    output logic          o_load_use
);

    logic w_rd_nonzero;
    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rd_nonzero = (i_ex_rd != '0);
    assign w_rs1_hit    = i_id_rs1_used && (i_id_rs1 == i_ex_rd);
    assign w_rs2_hit    = i_id_rs2_used && (i_id_rs2 == i_ex_rd);
    assign o_load_use   = i_ex_mem_read && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage load enables / sync clears for a 5-stage core.
// Ports: ID/EX/MEM hazard info in; pc_en, *_en, *_r (Mealy, same cycle) and md_busy (registered) out.
// Stall priority: memory wait > mul/div occupancy > branch flush > load-use. Optional macro
// PIPE_CTRL_PERF_EN adds stall_cycles / flush_count counters.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int MD_LAT = 4,
    parameter int RW     = 5
) (
    input  logic          clk,
    input  logic          r_n,
    input  logic [RW-1:0] id_rs1,
    input  logic [RW-1:0] id_rs2,
    input  logic          id_rs1_used,
    input  logic          id_rs2_used,
    input  logic [RW-1:0] ex_rd,
    input  logic          ex_mem_read,
    input  logic          ex_md_start,
    input  logic          ex_branch_taken,
    input  logic          mem_access,
    input  logic          dmem_ready,
    output logic          pc_en,
    output logic          if_id_en,
    output logic          id_ex_en,
    output logic          ex_mem_en,
    output logic          mem_wb_en,
    output logic          if_id_r,
    output logic          id_ex_r,
    output logic          ex_mem_r,
    output logic          mem_wb_r,
    output logic          md_busy
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]   stall_cycles,
    output logic [31:0]   flush_count
`endif
);

    localparam logic [7:0] MD_CNT_LOAD = md_cnt_load(MD_LAT);

    md_state_t  r_state;
    md_state_t  w_next_state;
    logic [7:0] r_md_cnt;
    logic [7:0] w_next_cnt;
    stage_ctl_t w_ctl;
    logic       w_load_use;
    logic       w_mem_stall;
    logic       w_md_occupy;
    logic       w_flush;

    hazard_detect #(
        .RW (RW)
    ) u_hazard_detect (
        .i_id_rs1      (id_rs1),
        .i_id_rs2      (id_rs2),
        .i_id_rs1_used (id_rs1_used),
        .i_id_rs2_used (id_rs2_used),
        .i_ex_rd       (ex_rd),
        .i_ex_mem_read (ex_mem_read),
        .o_load_use    (w_load_use)
    );

    assign w_mem_stall = mem_access && !dmem_ready;
    // ex_md_start only matters in RUN; in MD_BUSY the counter alone decides.
    assign w_md_occupy = ((r_state == RUN) && ex_md_start) ||
                         ((r_state == MD_BUSY) && (r_md_cnt != 8'd1));

    always_comb begin
        w_ctl        = CTL_ADVANCE;
        w_next_state = r_state;
        w_next_cnt   = r_md_cnt;
        w_flush      = 1'b0;

        if (w_mem_stall) begin
            // Freeze everything up to EX/MEM and feed a bubble into WB; FSM holds.
            w_ctl.pc_en     = 1'b0;
            w_ctl.if_id_en  = 1'b0;
            w_ctl.id_ex_en  = 1'b0;
            w_ctl.ex_mem_en = 1'b0;
            w_ctl.mem_wb_r  = 1'b1;
        end else if (w_md_occupy) begin
            // Mul/div holds EX; EX/MEM takes a bubble while MEM/WB drains.
            w_ctl.pc_en    = 1'b0;
            w_ctl.if_id_en = 1'b0;
            w_ctl.id_ex_en = 1'b0;
            w_ctl.ex_mem_r = 1'b1;
            if (r_state == RUN) begin
                w_next_state = MD_BUSY;
                w_next_cnt   = MD_CNT_LOAD;
            end else begin
                w_next_cnt = r_md_cnt - 8'd1;
            end
        end else begin
            // Release (if busy) is a normal advance that still honours flush/load-use.
            if (r_state == MD_BUSY) begin
                w_next_state = RUN;
                w_next_cnt   = 8'd0;
            end
            if (ex_branch_taken) begin
                w_ctl.if_id_r = 1'b1;
                w_ctl.id_ex_r = 1'b1;
                w_flush       = 1'b1;
            end else if (w_load_use) begin
                w_ctl.pc_en    = 1'b0;
                w_ctl.if_id_en = 1'b0;
                w_ctl.id_ex_r  = 1'b1;
            end
        end

        // Reset overrides the combinational outputs immediately, not just at the next edge.
        if (!r_n) begin
            w_ctl   = CTL_RESET;
            w_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_state  <= RUN;
            r_md_cnt <= 8'd0;
        end else begin
            r_state  <= w_next_state;
            r_md_cnt <= w_next_cnt;
        end
    end

    assign md_busy   = (r_state == MD_BUSY);

    assign pc_en     = w_ctl.pc_en;
    assign if_id_en  = w_ctl.if_id_en;
    assign id_ex_en  = w_ctl.id_ex_en;
    assign ex_mem_en = w_ctl.ex_mem_en;
    assign mem_wb_en = w_ctl.mem_wb_en;
    assign if_id_r   = w_ctl.if_id_r;
    assign id_ex_r   = w_ctl.id_ex_r;
    assign ex_mem_r  = w_ctl.ex_mem_r;
    assign mem_wb_r  = w_ctl.mem_wb_r;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_flush_count;

    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            r_stall_cycles <= 32'd0;
            r_flush_count  <= 32'd0;
        end else begin
            if (!w_ctl.pc_en) r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_flush)      r_flush_count  <= r_flush_count + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios plus randomized traffic,
// all compared against a row-priority reference model that counts mul/div cycles
// elapsed. Outputs are sampled 4 time units after the rising edge.
module tb_pipe_ctrl;

    localparam int MD_LAT = 4;
    localparam int RW     = 5;

    // Expected control words, bit order {pc,ifid,idex,exmem,memwb en ; ifid,idex,exmem,memwb r}.
    localparam logic [8:0] E_ADV   = 9'b11111_0000;
    localparam logic [8:0] E_MEM   = 9'b00001_0001;
    localparam logic [8:0] E_MD    = 9'b00011_0010;
    localparam logic [8:0] E_FLUSH = 9'b11111_1100;
    localparam logic [8:0] E_LU    = 9'b00111_0100;
    localparam logic [8:0] E_RST   = 9'b00000_1111;

    logic          clk = 1'b0;
    logic          r_n;
    logic [RW-1:0] id_rs1, id_rs2, ex_rd;
    logic          id_rs1_used, id_rs2_used, ex_mem_read, ex_md_start;
    logic          ex_branch_taken, mem_access, dmem_ready;
    logic          pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic          if_id_r, id_ex_r, ex_mem_r, mem_wb_r, md_busy;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]   stall_cycles, flush_count;
`endif

    always #5 clk = ~clk;

    pipe_ctrl #(
        .MD_LAT (MD_LAT),
        .RW     (RW)
    ) dut (
        .clk             (clk),
        .r_n             (r_n),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_rs1_used     (id_rs1_used),
        .id_rs2_used     (id_rs2_used),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_md_start     (ex_md_start),
        .ex_branch_taken (ex_branch_taken),
        .mem_access      (mem_access),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_r         (if_id_r),
        .id_ex_r         (id_ex_r),
        .ex_mem_r        (ex_mem_r),
        .mem_wb_r        (mem_wb_r),
        .md_busy         (md_busy)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: mul/div cycles already spent (0 = idle), perf counts.
    int md_elapsed = 0;
    int m_stalls   = 0;
    int m_flushes  = 0;
    // Observed tallies for scenario-level checks.
    int obs_pc0    = 0;
    int obs_busy   = 0;
    int obs_wbr    = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] obs_ctl();
        return {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_r, id_ex_r, ex_mem_r, mem_wb_r};
    endfunction

    task automatic idle_inputs();
        id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
        id_rs1_used = 1'b0; id_rs2_used = 1'b0; ex_mem_read = 1'b0;
        ex_md_start = 1'b0; ex_branch_taken = 1'b0;
        mem_access = 1'b0; dmem_ready = 1'b1;
    endtask

    task automatic clear_tallies();
        obs_pc0 = 0; obs_busy = 0; obs_wbr = 0;
    endtask

    // Called 1 unit after a rising edge with inputs set; checks the cycle and
    // advances the model, returning 1 unit after the next rising edge.
    task automatic step(input string tag);
        logic [8:0] exp;
        bit busy, ms, occ, rel, lu, fl;
        #3;
        busy = (md_elapsed > 0);
        ms   = mem_access && !dmem_ready;
        occ  = (!busy && ex_md_start) || (busy && md_elapsed < MD_LAT - 1);
        rel  = busy && (md_elapsed == MD_LAT - 1);
        lu   = ex_mem_read && (ex_rd != 0) &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        fl   = 1'b0;
        if (ms) begin
            exp = E_MEM;
        end else if (occ) begin
            exp = E_MD;
            md_elapsed++;
        end else begin
            if (rel) md_elapsed = 0;
            if (ex_branch_taken) begin
                exp = E_FLUSH;
                fl  = 1'b1;
            end else if (lu) begin
                exp = E_LU;
            end else begin
                exp = E_ADV;
            end
        end
        check_val({tag, ":ctl"}, 32'(obs_ctl()), 32'(exp));
        check_val({tag, ":md_busy"}, 32'(md_busy), 32'(busy));
`ifdef PIPE_CTRL_PERF_EN
        check_val({tag, ":stall_cycles"}, stall_cycles, 32'(m_stalls));
        check_val({tag, ":flush_count"}, flush_count, 32'(m_flushes));
`endif
        if (!exp[8]) m_stalls++;
        if (fl)      m_flushes++;
        if (!pc_en)   obs_pc0++;
        if (md_busy)  obs_busy++;
        if (mem_wb_r) obs_wbr++;
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between edges, checks the immediate response, releases after an edge.
    task automatic async_reset(input string tag);
        r_n = 1'b0;
        #1;
        check_val({tag, ":rst_ctl"}, 32'(obs_ctl()), 32'(E_RST));
        check_val({tag, ":rst_busy"}, 32'(md_busy), 32'd0);
`ifdef PIPE_CTRL_PERF_EN
        check_val({tag, ":rst_stall"}, stall_cycles, 32'd0);
        check_val({tag, ":rst_flush"}, flush_count, 32'd0);
`endif
        md_elapsed = 0;
        m_stalls   = 0;
        m_flushes  = 0;
        @(posedge clk);
        #1;
        r_n = 1'b1;
    endtask

    initial begin
        r_n = 1'b0;
        idle_inputs();
        #2;
        async_reset("init");

        // First cycle out of reset: normal advance.
        step("first");

        // Load-use on rs2, then the x0 and unused-source exclusions.
        idle_inputs();
        ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
        step("lu_hit");
        ex_rd = 5'd0; id_rs2 = 5'd0;
        step("lu_x0");
        ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b0;
        step("lu_unused");

        // Mul/div with start held through release: 3 stalls, busy for 3, advance on 4th.
        idle_inputs();
        clear_tallies();
        ex_md_start = 1'b1;
        for (int i = 0; i < MD_LAT; i++) step("md");
        check_val("md_stall_count", 32'(obs_pc0), 32'(MD_LAT - 1));
        check_val("md_busy_count", 32'(obs_busy), 32'(MD_LAT - 1));
        idle_inputs();
        step("md_after");

        // Mul/div overlapped by a 2-cycle memory wait: release slips by 2.
        clear_tallies();
        ex_md_start = 1'b1;
        step("mdm_start");
        ex_md_start = 1'b0;
        mem_access = 1'b1; dmem_ready = 1'b0;
        step("mdm_mem0");
        step("mdm_mem1");
        mem_access = 1'b0; dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step("mdm_tail");
        check_val("mdm_stall_count", 32'(obs_pc0), 32'd5);
        check_val("mdm_wb_bubbles", 32'(obs_wbr), 32'd2);

        // Branch flush beats a simultaneous load-use match.
        async_reset("pre_flush");
        idle_inputs();
        ex_branch_taken = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_rs1_used = 1'b1;
        step("flush_lu");
        idle_inputs();
        step("flush_after");
`ifdef PIPE_CTRL_PERF_EN
        check_val("flush_count_1", flush_count, 32'd1);
`endif

        // Reset in the middle of a mul/div.
        ex_md_start = 1'b1;
        step("mdr_start");
        ex_md_start = 1'b0;
        step("mdr_busy");
        async_reset("mdr");
        step("mdr_after");

        // Randomized traffic with occasional asynchronous resets.
        for (int n = 0; n < 3000; n++) begin
            id_rs1          = RW'($urandom_range(0, 3));
            id_rs2          = RW'($urandom_range(0, 3));
            ex_rd           = RW'($urandom_range(0, 3));
            id_rs1_used     = 1'($urandom_range(0, 1));
            id_rs2_used     = 1'($urandom_range(0, 1));
            ex_mem_read     = 1'($urandom_range(0, 1));
            ex_md_start     = ($urandom_range(0, 7) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
            mem_access      = 1'($urandom_range(0, 1));
            dmem_ready      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 299) == 0) async_reset("rand_rst");
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core. It drives the load-enable (`en`) and synchronous-clear (`r`) inputs of the four inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC enable. It resolves data-memory wait stalls, multi-cycle mul/div occupancy, taken-branch flushes and load-use hazards. It sits beside the datapath, takes hazard information from the ID, EX and MEM stages, and returns per-register control in the same cycle.

## Interface
Parameters:
- `MD_LAT`, default 4: number of cycles a mul/div instruction occupies EX. Legal values are 2 to 255.
- `RW`, default 5: width of register-file indices.

Ports:
- `clk` in 1: rising-edge clock.
- `r_n` in 1: reset, asynchronous, active-low.
- `id_rs1`, `id_rs2` in `RW`: source register indices of the instruction in ID.
- `id_rs1_used`, `id_rs2_used` in 1: the instruction in ID actually reads that source.
- `ex_rd` in `RW`: destination register index of the instruction in EX.
- `ex_mem_read` in 1: the instruction in EX is a load.
- `ex_md_start` in 1: the instruction in EX is a multi-cycle mul/div.
- `ex_branch_taken` in 1: a redirect was resolved in EX this cycle.
- `mem_access` in 1: the instruction in MEM is a load or store.
- `dmem_ready` in 1: data memory completes the MEM-stage access this cycle.
- `pc_en` out 1: PC register load enable.
- `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1: stage-register load enables.
- `if_id_r`, `id_ex_r`, `ex_mem_r`, `mem_wb_r` out 1: stage-register synchronous clears. A clear dominates its enable.
- `md_busy` out 1: FSM is in MD_BUSY.

## Operation
- Two-state FSM (RUN, MD_BUSY) plus an 8-bit down-counter `md_cnt`.
- All `*_en`/`*_r` outputs and `pc_en` are combinational, derived from the state and the current inputs (Mealy).
- Default, normal advance: every `en` = 1, every `r` = 0.
- Conditions are applied in strict priority order, highest first; only the first matching row applies:
  1. Memory stall: `mem_access && !dmem_ready`, in any state.
     - `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en` = 0.
     - `mem_wb_r` = 1, which inserts a bubble into WB.
     - State and `md_cnt` are frozen.
  2. MD occupancy: either RUN with `ex_md_start`, or MD_BUSY with `md_cnt != 1`.
     - `pc_en`, `if_id_en`, `id_ex_en` = 0.
     - `ex_mem_r` = 1; MEM/WB advances.
     - From RUN: load `md_cnt <= MD_LAT-1` and go to MD_BUSY.
     - In MD_BUSY: `md_cnt <= md_cnt-1`.
     - `ex_md_start` is ignored while in MD_BUSY.
  3. MD release: MD_BUSY with `md_cnt == 1`. Normal advance, EX/MEM captures the result, and the FSM goes to RUN. `ex_branch_taken` and the load-use check are still evaluated in this cycle (rows 4 and 5).
  4. Branch flush: `ex_branch_taken`. `pc_en` = 1 (target loaded); `if_id_r` = 1 and `id_ex_r` = 1.
  5. Load-use: all of the following must hold:
     - `ex_mem_read` is set and `ex_rd != 0`;
     - at least one ID source matches: (`id_rs1_used && id_rs1 == ex_rd`) or (`id_rs2_used && id_rs2 == ex_rd`).
     - Response: `pc_en` = 0, `if_id_en` = 0, `id_ex_r` = 1 (one bubble); EX/MEM and MEM/WB advance.
- A single mul/div instruction therefore costs exactly `MD_LAT-1` stall cycles when no memory stall overlaps it.

## Timing
- Reset, asynchronous, while `r_n` = 0:
  - state = RUN, `md_cnt` = 0, `md_busy` = 0;
  - `pc_en` and all `*_en` = 0; all `*_r` = 1.
- Reset mid-MD_BUSY aborts the operation; after reset the FSM is in RUN.
- First cycle after `r_n` rises: normal advance, unless an input condition fires.
- A memory stall overlapping MD_BUSY freezes the counter. The MD release is then delayed by exactly the number of memory-stall cycles.
- `md_busy` is registered, from the state: it goes high in the cycle after `ex_md_start` is sampled in RUN, and low in the cycle after release.
- `ex_rd == 0` never triggers a load-use stall.

## Configuration
- Macro: `PIPE_CTRL_PERF_EN`.
- With the macro defined, two 32-bit outputs are added, both reset to 0 and both wrapping on overflow:
  - `stall_cycles`: increments on every cycle with `pc_en == 0` while `r_n == 1`.
  - `flush_count`: increments on every branch-flush cycle.
- Without the macro, these ports and their counters are absent.

## Structure
- Shared package `pipe_pkg`:
  - state encoding: RUN = 1'b0, MD_BUSY = 1'b1;
  - the stage-control bundle ordering;
  - the `MD_LAT` range limits.
- One sub-module, `hazard_detect`: purely combinational load-use comparator (rs/rd compare, `x0` exclusion), instantiated once.

## Test plan
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rs2`=5, `id_rs2_used`=1 → one cycle with `pc_en`=0, `if_id_en`=0, `id_ex_r`=1, `ex_mem_en`=1.
- Same stimulus with `ex_rd`=0, or with `id_rs2_used`=0 → no stall (all `en`=1, all `r`=0).
- `MD_LAT`=4, one-cycle `ex_md_start` pulse held until release → 3 stall cycles with `ex_mem_r`=1; `md_busy` high for 3 cycles; normal advance on the 4th cycle.
- `MD_LAT`=4, `mem_access`=1 with `dmem_ready`=0 for 2 cycles during MD_BUSY → `mem_wb_r`=1 for those 2 cycles; total of 5 cycles with `pc_en`=0.
- `ex_branch_taken`=1 together with a load-use match → `if_id_r`=1, `id_ex_r`=1, `pc_en`=1; with `PIPE_CTRL_PERF_EN`, `flush_count` goes 0→1.
- Pull `r_n` low mid-MD_BUSY → immediately all `*_r`=1, `pc_en`=0 and `md_busy`=0; after `r_n` rises, the FSM is in RUN with normal advance.
